// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: captures ID-stage control, operands and register
// indices for one cycle, with stall (hold), flush (bubble) and a valid flag.
module id_ex_reg #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic              Branch_i,
  input  logic              MemRead_i,
  input  logic              MemtoReg_i,
  input  logic [1:0]        ALUOp_i,
  input  logic              MemWrite_i,
  input  logic              ALUSrc_i,
  input  logic              RegWrite_i,
  input  logic [XLEN-1:0]   RS1data_i,
  input  logic [XLEN-1:0]   RS2data_i,
  input  logic [XLEN-1:0]   Imm_i,
  input  logic [XLEN-1:0]   PC_i,
  input  logic [9:0]        Funct_i,
  input  logic [REG_AW-1:0] RS1addr_i,
  input  logic [REG_AW-1:0] RS2addr_i,
  input  logic [REG_AW-1:0] RDaddr_i,
  output logic              valid_o,
  output logic              Branch_o,
  output logic              MemRead_o,
  output logic              MemtoReg_o,
  output logic [1:0]        ALUOp_o,
  output logic              MemWrite_o,
  output logic              ALUSrc_o,
  output logic              RegWrite_o,
  output logic [XLEN-1:0]   RS1data_o,
  output logic [XLEN-1:0]   RS2data_o,
  output logic [XLEN-1:0]   Imm_o,
  output logic [XLEN-1:0]   PC_o,
  output logic [9:0]        Funct_o,
  output logic [REG_AW-1:0] RS1addr_o,
  output logic [REG_AW-1:0] RS2addr_o,
  output logic [REG_AW-1:0] RDaddr_o
);

  logic              valid_q,    valid_d;
  logic              branch_q,   branch_d;
  logic              memread_q,  memread_d;
  logic              memtoreg_q, memtoreg_d;
  logic [1:0]        aluop_q,    aluop_d;
  logic              memwrite_q, memwrite_d;
  logic              alusrc_q,   alusrc_d;
  logic              regwrite_q, regwrite_d;
  logic [XLEN-1:0]   rs1data_q,  rs1data_d;
  logic [XLEN-1:0]   rs2data_q,  rs2data_d;
  logic [XLEN-1:0]   imm_q,      imm_d;
  logic [XLEN-1:0]   pc_q,       pc_d;
  logic [9:0]        funct_q,    funct_d;
  logic [REG_AW-1:0] rs1addr_q,  rs1addr_d;
  logic [REG_AW-1:0] rs2addr_q,  rs2addr_d;
  logic [REG_AW-1:0] rdaddr_q,   rdaddr_d;

  logic load_bubble;
  logic load_input;

  // An invalid ID slot is loaded as a bubble so it can never carry side effects.
  assign load_bubble = flush_i | (~stall_i & ~valid_i);
  assign load_input  = ~flush_i & ~stall_i & valid_i;

  always_comb begin
    valid_d    = valid_q;
    branch_d   = branch_q;
    memread_d  = memread_q;
    memtoreg_d = memtoreg_q;
    aluop_d    = aluop_q;
    memwrite_d = memwrite_q;
    alusrc_d   = alusrc_q;
    regwrite_d = regwrite_q;
    rs1data_d  = rs1data_q;
    rs2data_d  = rs2data_q;
    imm_d      = imm_q;
    pc_d       = pc_q;
    funct_d    = funct_q;
    rs1addr_d  = rs1addr_q;
    rs2addr_d  = rs2addr_q;
    rdaddr_d   = rdaddr_q;
    if (load_bubble) begin
      valid_d    = 1'b0;
      branch_d   = 1'b0;
      memread_d  = 1'b0;
      memtoreg_d = 1'b0;
      aluop_d    = 2'b00;
      memwrite_d = 1'b0;
      alusrc_d   = 1'b0;
      regwrite_d = 1'b0;
      rs1data_d  = '0;
      rs2data_d  = '0;
      imm_d      = '0;
      pc_d       = '0;
      funct_d    = '0;
      rs1addr_d  = '0;
      rs2addr_d  = '0;
      rdaddr_d   = '0;
    end else if (load_input) begin
      valid_d    = valid_i;
      branch_d   = Branch_i;
      memread_d  = MemRead_i;
      memtoreg_d = MemtoReg_i;
      aluop_d    = ALUOp_i;
      memwrite_d = MemWrite_i;
      alusrc_d   = ALUSrc_i;
      regwrite_d = RegWrite_i;
      rs1data_d  = RS1data_i;
      rs2data_d  = RS2data_i;
      imm_d      = Imm_i;
      pc_d       = PC_i;
      funct_d    = Funct_i;
      rs1addr_d  = RS1addr_i;
      rs2addr_d  = RS2addr_i;
      rdaddr_d   = RDaddr_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q    <= 1'b0;
      branch_q   <= 1'b0;
      memread_q  <= 1'b0;
      memtoreg_q <= 1'b0;
      aluop_q    <= 2'b00;
      memwrite_q <= 1'b0;
      alusrc_q   <= 1'b0;
      regwrite_q <= 1'b0;
      rs1data_q  <= '0;
      rs2data_q  <= '0;
      imm_q      <= '0;
      pc_q       <= '0;
      funct_q    <= '0;
      rs1addr_q  <= '0;
      rs2addr_q  <= '0;
      rdaddr_q   <= '0;
    end else begin
      valid_q    <= valid_d;
      branch_q   <= branch_d;
      memread_q  <= memread_d;
      memtoreg_q <= memtoreg_d;
      aluop_q    <= aluop_d;
      memwrite_q <= memwrite_d;
      alusrc_q   <= alusrc_d;
      regwrite_q <= regwrite_d;
      rs1data_q  <= rs1data_d;
      rs2data_q  <= rs2data_d;
      imm_q      <= imm_d;
      pc_q       <= pc_d;
      funct_q    <= funct_d;
      rs1addr_q  <= rs1addr_d;
      rs2addr_q  <= rs2addr_d;
      rdaddr_q   <= rdaddr_d;
    end
  end

  assign valid_o    = valid_q;
  assign Branch_o   = branch_q;
  assign MemRead_o  = memread_q;
  assign MemtoReg_o = memtoreg_q;
  assign ALUOp_o    = aluop_q;
  assign MemWrite_o = memwrite_q;
  assign ALUSrc_o   = alusrc_q;
  assign RegWrite_o = regwrite_q;
  assign RS1data_o  = rs1data_q;
  assign RS2data_o  = rs2data_q;
  assign Imm_o      = imm_q;
  assign PC_o       = pc_q;
  assign Funct_o    = funct_q;
  assign RS1addr_o  = rs1addr_q;
  assign RS2addr_o  = rs2addr_q;
  assign RDaddr_o   = rdaddr_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: directed scenarios plus randomized
// traffic compared against a slot-level reference model.
module tb_id_ex_reg;

  typedef struct packed {
    logic        valid;
    logic        Branch;
    logic        MemRead;
    logic        MemtoReg;
    logic [1:0]  ALUOp;
    logic        MemWrite;
    logic        ALUSrc;
    logic        RegWrite;
    logic [31:0] RS1data;
    logic [31:0] RS2data;
    logic [31:0] Imm;
    logic [31:0] PC;
    logic [9:0]  Funct;
    logic [4:0]  RS1addr;
    logic [4:0]  RS2addr;
    logic [4:0]  RDaddr;
  } slot_t;

  logic  clk_i = 1'b0;
  logic  rst_i;
  logic  stall_i;
  logic  flush_i;
  slot_t in_s;
  slot_t out_s;
  slot_t exp_s;
  int    checks = 0;
  int    errors = 0;

  always #5 clk_i = ~clk_i;

  id_ex_reg #(.XLEN(32), .REG_AW(5)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .stall_i    (stall_i),
    .flush_i    (flush_i),
    .valid_i    (in_s.valid),
    .Branch_i   (in_s.Branch),
    .MemRead_i  (in_s.MemRead),
    .MemtoReg_i (in_s.MemtoReg),
    .ALUOp_i    (in_s.ALUOp),
    .MemWrite_i (in_s.MemWrite),
    .ALUSrc_i   (in_s.ALUSrc),
    .RegWrite_i (in_s.RegWrite),
    .RS1data_i  (in_s.RS1data),
    .RS2data_i  (in_s.RS2data),
    .Imm_i      (in_s.Imm),
    .PC_i       (in_s.PC),
    .Funct_i    (in_s.Funct),
    .RS1addr_i  (in_s.RS1addr),
    .RS2addr_i  (in_s.RS2addr),
    .RDaddr_i   (in_s.RDaddr),
    .valid_o    (out_s.valid),
    .Branch_o   (out_s.Branch),
    .MemRead_o  (out_s.MemRead),
    .MemtoReg_o (out_s.MemtoReg),
    .ALUOp_o    (out_s.ALUOp),
    .MemWrite_o (out_s.MemWrite),
    .ALUSrc_o   (out_s.ALUSrc),
    .RegWrite_o (out_s.RegWrite),
    .RS1data_o  (out_s.RS1data),
    .RS2data_o  (out_s.RS2data),
    .Imm_o      (out_s.Imm),
    .PC_o       (out_s.PC),
    .Funct_o    (out_s.Funct),
    .RS1addr_o  (out_s.RS1addr),
    .RS2addr_o  (out_s.RS2addr),
    .RDaddr_o   (out_s.RDaddr)
  );

  // What EX should see after an edge: a bubble, the previous slot, or the new one.
  function automatic slot_t model_next(slot_t cur, slot_t nxt, logic stall, logic flush);
    if (flush) return '0;
    if (stall) return cur;
    if (!nxt.valid) return '0;
    return nxt;
  endfunction

  function automatic slot_t rand_slot();
    slot_t s;
    s.valid    = 1'($urandom);
    s.Branch   = 1'($urandom);
    s.MemRead  = 1'($urandom);
    s.MemtoReg = 1'($urandom);
    s.ALUOp    = 2'($urandom);
    s.MemWrite = 1'($urandom);
    s.ALUSrc   = 1'($urandom);
    s.RegWrite = 1'($urandom);
    s.RS1data  = $urandom;
    s.RS2data  = $urandom;
    s.Imm      = $urandom;
    s.PC       = $urandom;
    s.Funct    = 10'($urandom);
    s.RS1addr  = 5'($urandom);
    s.RS2addr  = 5'($urandom);
    s.RDaddr   = 5'($urandom);
    return s;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    exp_s = model_next(exp_s, in_s, stall_i, flush_i);
    #1;
  endtask

  task automatic test_reset();
    in_s = rand_slot();
    in_s.valid = 1'b1;
    in_s.RS1data = 32'hDEAD_BEEF;
    in_s.RegWrite = 1'b1;
    in_s.RDaddr = 5'd7;
    tick();
    checks++;
    if (out_s !== exp_s) begin
      errors++;
      $display("FAIL preload: got %h want %h", out_s, exp_s);
    end
    #3 rst_i = 1'b0;
    #1;
    checks++;
    if (out_s !== '0) begin
      errors++;
      $display("FAIL async_reset: got %h want 0", out_s);
    end
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    checks++;
    if (out_s !== '0) begin
      errors++;
      $display("FAIL reset_hold: got %h want 0", out_s);
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    exp_s = '0;
  endtask

  task automatic test_capture();
    in_s = '0;
    in_s.valid = 1'b1;
    in_s.ALUOp = 2'b10;
    in_s.ALUSrc = 1'b1;
    in_s.RegWrite = 1'b1;
    in_s.Imm = 32'hFFFF_FFF0;
    in_s.PC = 32'h0000_0040;
    in_s.Funct = 10'b0000000_000;
    in_s.RDaddr = 5'd3;
    tick();
    checks++;
    if (out_s !== in_s) begin
      errors++;
      $display("FAIL capture: got %h want %h", out_s, in_s);
    end
    in_s = rand_slot();
    in_s.valid = 1'b1;
    tick();
    checks++;
    if (out_s !== exp_s) begin
      errors++;
      $display("FAIL capture_next: got %h want %h", out_s, exp_s);
    end
  endtask

  task automatic test_stall();
    in_s = rand_slot();
    in_s.valid = 1'b1;
    in_s.RDaddr = 5'd9;
    in_s.RS2data = 32'h1234_5678;
    tick();
    stall_i = 1'b1;
    in_s.RDaddr = 5'd1;
    in_s.RS2data = 32'hCAFE_0001;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_s.RDaddr !== 5'd9 || out_s.RS2data !== 32'h1234_5678) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got rd=%0d rs2=%h want rd=9 rs2=12345678",
                 i, out_s.RDaddr, out_s.RS2data);
      end
    end
    stall_i = 1'b0;
    tick();
    checks++;
    if (out_s.RDaddr !== 5'd1 || out_s !== exp_s) begin
      errors++;
      $display("FAIL stall_release: got %h want %h", out_s, exp_s);
    end
  endtask

  task automatic test_flush_priority();
    in_s = rand_slot();
    in_s.valid = 1'b1;
    in_s.RS1data = 32'h0BAD_F00D;
    in_s.ALUOp = 2'b11;
    in_s.RDaddr = 5'd12;
    tick();
    flush_i = 1'b1;
    stall_i = 1'b1;
    in_s.MemWrite = 1'b1;
    in_s.RegWrite = 1'b1;
    tick();
    checks++;
    if (out_s.valid !== 1'b0 || out_s.MemWrite !== 1'b0 || out_s.RegWrite !== 1'b0 ||
        out_s.ALUOp !== 2'b00 || out_s.RDaddr !== 5'd0 || out_s.RS1data !== 32'd0) begin
      errors++;
      $display("FAIL flush_over_stall: got %h want key fields 0", out_s);
    end
    checks++;
    if (out_s !== '0) begin
      errors++;
      $display("FAIL flush_all_zero: got %h want 0", out_s);
    end
    flush_i = 1'b0;
    stall_i = 1'b0;
  endtask

  task automatic test_invalid_slot();
    in_s = rand_slot();
    in_s.valid = 1'b0;
    in_s.RegWrite = 1'b1;
    in_s.MemRead = 1'b1;
    in_s.RDaddr = 5'd5;
    tick();
    checks++;
    if (out_s.valid !== 1'b0 || out_s.RegWrite !== 1'b0 || out_s.MemRead !== 1'b0 ||
        out_s.RDaddr !== 5'd0) begin
      errors++;
      $display("FAIL invalid_slot: got valid=%b rw=%b mr=%b rd=%0d want all 0",
               out_s.valid, out_s.RegWrite, out_s.MemRead, out_s.RDaddr);
    end
  endtask

  task automatic test_hazard_bubble_and_reset();
    in_s = rand_slot();
    in_s.valid = 1'b1;
    in_s.Branch = 1'b0;
    in_s.MemRead = 1'b0;
    in_s.MemtoReg = 1'b0;
    in_s.ALUOp = 2'b00;
    in_s.MemWrite = 1'b0;
    in_s.ALUSrc = 1'b0;
    in_s.RegWrite = 1'b0;
    in_s.RDaddr = 5'd4;
    tick();
    checks++;
    if (out_s.valid !== 1'b1 || out_s.RDaddr !== 5'd4 || out_s.RegWrite !== 1'b0 ||
        out_s.MemRead !== 1'b0 || out_s !== in_s) begin
      errors++;
      $display("FAIL hazard_bubble: got %h want %h", out_s, in_s);
    end
    stall_i = 1'b1;
    in_s = rand_slot();
    tick();
    #2 rst_i = 1'b0;
    #1;
    checks++;
    if (out_s !== '0) begin
      errors++;
      $display("FAIL reset_mid_stall: got %h want 0", out_s);
    end
    @(negedge clk_i);
    stall_i = 1'b0;
    rst_i = 1'b1;
    exp_s = '0;
    in_s = rand_slot();
    in_s.valid = 1'b1;
    tick();
    checks++;
    if (out_s !== in_s) begin
      errors++;
      $display("FAIL after_reset_capture: got %h want %h", out_s, in_s);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      in_s = rand_slot();
      stall_i = ($urandom_range(0, 3) == 0);
      flush_i = ($urandom_range(0, 5) == 0);
      tick();
      checks++;
      if (out_s !== exp_s) begin
        errors++;
        $display("FAIL random[%0d]: got %h want %h", i, out_s, exp_s);
      end
    end
    stall_i = 1'b0;
    flush_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_i = 1'b0;
    stall_i = 1'b0;
    flush_i = 1'b0;
    in_s = '0;
    exp_s = '0;
    #12 rst_i = 1'b1;
    test_reset();
    test_capture();
    test_stall();
    test_flush_priority();
    test_invalid_slot();
    test_hazard_bubble_and_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_reg.md
Name: id_ex_reg

Overview:
- ID/EX pipeline register of the 5-stage RISC-V core.
- Sits directly downstream of the ID-stage control-zeroing mux, which forces control signals to 0 on a load-use hazard. It captures those control signals together with ID-stage operands and register indices, and presents them to EX for one cycle.
- Supports pipeline stall (hold) and flush (bubble insertion). Adds a valid flag so EX and forwarding logic can tell real instructions from bubbles.

Parameters:
- XLEN, 32, datapath width for register data, immediate and PC.
- REG_AW, 5, register-index width.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- stall_i  input  1  hold all contents this cycle.
- flush_i  input  1  load a bubble this cycle.
- valid_i  input  1  ID holds a real instruction.
- Branch_i  input  1  control from ID control mux.
- MemRead_i  input  1  control.
- MemtoReg_i  input  1  control.
- ALUOp_i  input  2  control.
- MemWrite_i  input  1  control.
- ALUSrc_i  input  1  control.
- RegWrite_i  input  1  control.
- RS1data_i  input  XLEN  register-file read port 1.
- RS2data_i  input  XLEN  register-file read port 2.
- Imm_i  input  XLEN  sign-extended immediate.
- PC_i  input  XLEN  PC of the ID instruction.
- Funct_i  input  10  {funct7, funct3}.
- RS1addr_i  input  REG_AW  source index 1.
- RS2addr_i  input  REG_AW  source index 2.
- RDaddr_i  input  REG_AW  destination index.
- Outputs, each output 1:1 registered copy of the matching input, same width:
  - valid_o, Branch_o, MemRead_o, MemtoReg_o, ALUOp_o, MemWrite_o, ALUSrc_o, RegWrite_o
  - RS1data_o, RS2data_o, Imm_o, PC_o, Funct_o, RS1addr_o, RS2addr_o, RDaddr_o

Behaviour:
- Reset:
  - rst_i low asynchronously clears every output to 0 (valid_o=0, all controls 0, all data/index 0), independent of clk_i.
  - Deassertion takes effect at the next rising edge. No capture occurs on the edge coincident with deassertion unless rst_i is already high at setup.
- Per rising edge, priority order:
  1. flush_i=1: bubble. valid_o, Branch_o, MemRead_o, MemtoReg_o, MemWrite_o, RegWrite_o, ALUSrc_o = 0; ALUOp_o = 2'b00; RDaddr_o, RS1addr_o, RS2addr_o = 0 (prevents spurious forwarding matches). Data fields (RS1data_o, RS2data_o, Imm_o, PC_o, Funct_o) are also cleared to 0, so bubbles are deterministic.
  2. else stall_i=1: every output holds its previous value.
  3. else: capture all inputs.
- Flush and stall both high: flush wins.
- Latency: exactly 1 cycle from input to output. No combinational path from any input to any output.
- Bubble suppression on capture: if valid_i=0, the register captures as if flush_i were 1. This guarantees an invalid slot never carries RegWrite/MemWrite/MemRead/Branch.
- No arithmetic or width conversion; all fields pass bit-exact.
- Reset asserted mid-stall or mid-flush: reset overrides immediately. The stall/flush request is not remembered after reset release.
- A zeroed-control slot from the upstream hazard mux with valid_i=1 is captured as-is (valid_o=1, controls 0). This is legal and is not treated as a flush.

Test Plan:
1. Reset:
   - Stimulus: drive all inputs nonzero (RS1data_i=32'hDEAD_BEEF, RegWrite_i=1, RDaddr_i=5'd7, valid_i=1); pull rst_i low between clock edges.
   - Required: all outputs 0 immediately, without waiting for a clock edge. They stay 0 while rst_i is low.
2. Normal capture:
   - Stimulus: rst_i high; valid_i=1, ALUOp_i=2'b10, ALUSrc_i=1, RegWrite_i=1, Imm_i=32'hFFFF_FFF0, PC_i=32'h0000_0040, Funct_i=10'b0000000_000, RDaddr_i=5'd3.
   - Required: after one edge, outputs equal the inputs exactly. The values change on the next edge when the inputs change.
3. Stall hold:
   - Stimulus: load RDaddr_i=5'd9, RS2data_i=32'h1234_5678; then assert stall_i for 3 edges while inputs change to RDaddr_i=5'd1.
   - Required: RDaddr_o stays 9 and RS2data_o stays 32'h1234_5678 for all 3 edges. The new values appear on the first edge after stall_i drops.
4. Flush priority:
   - Stimulus: valid contents loaded; assert flush_i=1 and stall_i=1 together, with MemWrite_i=1 and RegWrite_i=1.
   - Required: after the edge, valid_o=0, MemWrite_o=0, RegWrite_o=0, ALUOp_o=0, RDaddr_o=0, RS1data_o=0.
5. Invalid slot:
   - Stimulus: valid_i=0, RegWrite_i=1, MemRead_i=1, RDaddr_i=5'd5, no flush or stall.
   - Required: after the edge, valid_o=0, RegWrite_o=0, MemRead_o=0, RDaddr_o=0.
6. Hazard bubble versus flush, then reset during stall:
   - Stimulus A: valid_i=1 with all controls 0 and RDaddr_i=5'd4.
   - Required A: valid_o=1, controls 0, RDaddr_o=4.
   - Stimulus B: then assert stall_i and, mid-stall, pull rst_i low.
   - Required B: all outputs go to 0 at once. After release with stall_i=0, the next edge captures fresh inputs.
